// File: rtl/rotary_input_conditioner.sv
// Rotary encoder pin conditioner: sync, debounce, step classification.
// Presents clean a/b, one-cycle cw/ccw/err strobes and a wrapping position.
module rotary_input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       a_raw,
    input  logic       b_raw,
    output logic       a,
    output logic       b,
    output logic       change,
    output logic       cw,
    output logic       ccw,
    output logic       err,
    output logic [7:0] position
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX =
        CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    logic                 a_m;
    logic                 b_m;
    logic                 s_a;
    logic                 s_b;
    logic [CNT_WIDTH-1:0] cnt_a;
    logic [CNT_WIDTH-1:0] cnt_b;
    logic [CNT_WIDTH-1:0] cnt_a_nxt;
    logic [CNT_WIDTH-1:0] cnt_b_nxt;
    logic                 a_nxt;
    logic                 b_nxt;
    logic [1:0]           ab_diff;
    logic [1:0]           idx_old;
    logic [1:0]           idx_new;
    logic                 fwd;
    logic                 cw_nxt;
    logic                 ccw_nxt;
    logic                 err_nxt;
    logic [7:0]           pos_nxt;

    // Two-flop synchronizers for the asynchronous encoder pins
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_m <= 1'b0;
            b_m <= 1'b0;
            s_a <= 1'b0;
            s_b <= 1'b0;
        end else begin
            a_m <= a_raw;
            b_m <= b_raw;
            s_a <= a_m;
            s_b <= b_m;
        end
    end

    // Per-channel debounce: accept a level after a full run of mismatches
    always_comb begin
        a_nxt     = a;
        b_nxt     = b;
        cnt_a_nxt = '0;
        cnt_b_nxt = '0;
        if (s_a != a) begin
            if (cnt_a == CNT_MAX) begin
                a_nxt = s_a;
            end else begin
                cnt_a_nxt = cnt_a + CNT_ONE;
            end
        end
        if (s_b != b) begin
            if (cnt_b == CNT_MAX) begin
                b_nxt = s_b;
            end else begin
                cnt_b_nxt = cnt_b + CNT_ONE;
            end
        end
    end

    // Classify old->new {a,b}; the cw cycle 00,10,11,01 is Gray code on {b,a}
    always_comb begin
        ab_diff = {a ^ a_nxt, b ^ b_nxt};
        idx_old = {b, b ^ a};
        idx_new = {b_nxt, b_nxt ^ a_nxt};
        fwd     = (idx_new == idx_old + 2'd1);
        cw_nxt  = 1'b0;
        ccw_nxt = 1'b0;
        err_nxt = 1'b0;
        pos_nxt = position;
        unique case (1'b1)
            (ab_diff == 2'b11): begin
                err_nxt = 1'b1;
            end
            (ab_diff != 2'b00 && ab_diff != 2'b11 && fwd): begin
                cw_nxt  = 1'b1;
                pos_nxt = position + 8'd1;
            end
            (ab_diff != 2'b00 && ab_diff != 2'b11 && !fwd): begin
                ccw_nxt = 1'b1;
                pos_nxt = position - 8'd1;
            end
            default: begin
                pos_nxt = position;
            end
        endcase
    end

    // Debounce state, clean outputs, strobes and position register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_a    <= '0;
            cnt_b    <= '0;
            a        <= 1'b0;
            b        <= 1'b0;
            change   <= 1'b0;
            cw       <= 1'b0;
            ccw      <= 1'b0;
            err      <= 1'b0;
            position <= 8'd0;
        end else begin
            cnt_a    <= cnt_a_nxt;
            cnt_b    <= cnt_b_nxt;
            a        <= a_nxt;
            b        <= b_nxt;
            change   <= cw_nxt | ccw_nxt | err_nxt;
            cw       <= cw_nxt;
            ccw      <= ccw_nxt;
            err      <= err_nxt;
            position <= pos_nxt;
        end
    end

endmodule

// File: tb/tb_rotary_input_conditioner.sv
// Directed bench for rotary_input_conditioner with DEBOUNCE_CYCLES=4.
// Observed vector is {a,b,change,cw,ccw,err,position}.
module tb_rotary_input_conditioner;

    logic       clk;
    logic       reset_n;
    logic       a_raw;
    logic       b_raw;
    logic       a;
    logic       b;
    logic       change;
    logic       cw;
    logic       ccw;
    logic       err;
    logic [7:0] position;
    logic [13:0] obs;

    int errors;
    int checks;

    rotary_input_conditioner #(
        .DEBOUNCE_CYCLES(4),
        .CNT_WIDTH(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .a_raw(a_raw),
        .b_raw(b_raw),
        .a(a),
        .b(b),
        .change(change),
        .cw(cw),
        .ccw(ccw),
        .err(err),
        .position(position)
    );

    assign obs = {a, b, change, cw, ccw, err, position};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (obs !== 14'd0) begin
                errors++;
                $display("FAIL reset c%0d: got %b want %b", i, obs, 14'd0);
            end
        end
        a_raw = 1'b0;
        b_raw = 1'b0;
        reset_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL reset_idle: got %b want %b", obs, 14'd0);
        end
    endtask

    task automatic test_cw_step();
        logic [13:0] exp;
        a_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6) exp = 14'd0;
            else if (e == 6) exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
            else exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL cw_step e%0d: got %b want %b", e, obs, exp);
            end
        end
        a_raw = 1'b0;
        repeat (10) tick();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL cw_step_back: got %b want %b", obs, 14'd0);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            a_raw = ((i / 2) % 2) == 0;
            tick();
            checks++;
            if (obs !== 14'd0) begin
                errors++;
                $display("FAIL bounce c%0d: got %b want %b", i, obs, 14'd0);
            end
        end
        a_raw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs !== 14'd0) begin
                errors++;
                $display("FAIL bounce_hold c%0d: got %b want %b",
                         i, obs, 14'd0);
            end
        end
    endtask

    task automatic test_ccw_wrap();
        logic [1:0] seq [4];
        logic [7:0] pos [4];
        int ncw, nccw, nerr;
        seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        pos = '{8'd255, 8'd254, 8'd253, 8'd252};
        for (int s = 0; s < 4; s++) begin
            {a_raw, b_raw} = seq[s];
            ncw = 0;
            nccw = 0;
            nerr = 0;
            repeat (10) begin
                tick();
                ncw += int'(cw);
                nccw += int'(ccw);
                nerr += int'(err);
            end
            checks++;
            if (nccw != 1 || ncw != 0 || nerr != 0) begin
                errors++;
                $display("FAIL ccw_pulses s%0d: got cw=%0d ccw=%0d err=%0d want 0 1 0",
                         s, ncw, nccw, nerr);
            end
            checks++;
            if ({a, b, position} !== {seq[s], pos[s]}) begin
                errors++;
                $display("FAIL ccw_pos s%0d: got %b want %b",
                         s, {a, b, position}, {seq[s], pos[s]});
            end
        end
    endtask

    task automatic test_cw_wrap();
        logic [1:0] seq [4];
        logic [7:0] pos [4];
        int ncw, nccw, nerr;
        seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        pos = '{8'd253, 8'd254, 8'd255, 8'd0};
        for (int s = 0; s < 4; s++) begin
            {a_raw, b_raw} = seq[s];
            ncw = 0;
            nccw = 0;
            nerr = 0;
            repeat (10) begin
                tick();
                ncw += int'(cw);
                nccw += int'(ccw);
                nerr += int'(err);
            end
            checks++;
            if (ncw != 1 || nccw != 0 || nerr != 0) begin
                errors++;
                $display("FAIL cw_pulses s%0d: got cw=%0d ccw=%0d err=%0d want 1 0 0",
                         s, ncw, nccw, nerr);
            end
            checks++;
            if ({a, b, position} !== {seq[s], pos[s]}) begin
                errors++;
                $display("FAIL cw_pos s%0d: got %b want %b",
                         s, {a, b, position}, {seq[s], pos[s]});
            end
        end
    endtask

    task automatic test_simultaneous();
        logic [13:0] exp;
        a_raw = 1'b1;
        b_raw = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6) exp = 14'd0;
            else if (e == 6) exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'd0};
            else exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL simul e%0d: got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [13:0] exp;
        a_raw = 1'b0;
        tick();
        b_raw = 1'b0;
        for (int e = 2; e <= 8; e++) begin
            tick();
            if (e < 6) exp = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
            else if (e == 6) exp = {1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
            else if (e == 7) exp = {1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd2};
            else exp = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL back_to_back e%0d: got %b want %b", e, obs, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [13:0] exp;
        a_raw = 1'b1;
        repeat (3) tick();
        reset_n = 1'b0;
        tick();
        checks++;
        if (obs !== 14'd0) begin
            errors++;
            $display("FAIL reset_mid_clear: got %b want %b", obs, 14'd0);
        end
        reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            tick();
            if (e < 6) exp = 14'd0;
            else if (e == 6) exp = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'd1};
            else exp = {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL reset_mid e%0d: got %b want %b", e, obs, exp);
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        reset_n = 1'b0;
        a_raw = 1'b0;
        b_raw = 1'b0;
        test_reset();
        test_cw_step();
        test_bounce();
        test_ccw_wrap();
        test_cw_wrap();
        test_simultaneous();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rotary_input_conditioner.md
# rotary_input_conditioner

Conditions the two raw rotary-encoder pins before they reach the rotary encoder decoder, which turns `{a,b}` into an ASCII value for the FIFO-to-USB path. Each pin is synchronized and debounced, and the clean pair is presented as `a`/`b`. Each accepted transition is classified as clockwise, counter-clockwise or illegal and reported with a one-cycle strobe, and an 8-bit wrapping position count is kept.

## Interface
- `DEBOUNCE_CYCLES`, default 50000: consecutive mismatching samples needed to accept a new pin level (1 ms at 50 MHz). Must be ≥ 2.
- `CNT_WIDTH`, default 16: debounce counter width. Must hold `DEBOUNCE_CYCLES-1`.

Ports:
- `clk` in 1: system clock. The block uses only this clock.
- `reset_n` in 1: synchronous, active-low reset.
- `a_raw` in 1: encoder channel A, asynchronous to `clk`.
- `b_raw` in 1: encoder channel B, asynchronous to `clk`.
- `a` out 1: debounced channel A. Feeds the decoder's `a`.
- `b` out 1: debounced channel B. Feeds the decoder's `b`.
- `change` out 1: one-cycle pulse when `{a,b}` takes a new value.
- `cw` out 1: one-cycle pulse for a legal clockwise step.
- `ccw` out 1: one-cycle pulse for a legal counter-clockwise step.
- `err` out 1: one-cycle pulse when both channels change on the same edge.
- `position` out 8: step count, unsigned and wrapping.

## Operation
- **Synchronizer:** two flip-flops per pin. The second-stage output is the sample `s_a`/`s_b`.
- **Debounce,** independent per channel, with counter `cnt_x`:
  - If `s_x == x`: `cnt_x` is cleared to 0.
  - If `s_x != x` and `cnt_x != DEBOUNCE_CYCLES-1`: `cnt_x` increments.
  - If `s_x != x` and `cnt_x == DEBOUNCE_CYCLES-1`: `x` takes `s_x` and `cnt_x` is cleared.
  - Any single sample that agrees with the current output restarts the count (bounce rejection).
- **Classification** compares the old `{a,b}` with the new `{a,b}` on the edge where either channel updates. Pulses are registered on that same edge, so they are high during the first cycle the new `{a,b}` is visible.
  - Clockwise sequence: 00→10→11→01→00 (A leads). A step along it gives `cw=1`, `change=1`, `position+1`.
  - Counter-clockwise sequence: 01→11→10→00→01. A step along it gives `ccw=1`, `change=1`, `position-1`.
  - Both bits change on the same edge: `err=1`, `change=1`, `position` unchanged.
- At most one of `cw`/`ccw`/`err` is high in any cycle. `change` is high exactly when one of them is high.
- `position` wraps modulo 256: 255+1 gives 0, and 0-1 gives 255.
- **Reset** (`reset_n` low at a `clk` edge) clears to 0: the sync flops, both counters, `a`, `b`, `change`, `cw`, `ccw`, `err` and `position`.
- **Reset mid-operation** discards any debounce in progress. After release the block behaves as from power-up: a pin held at 1 is re-accepted as a fresh transition away from 00.

## Timing
- Every output is 0 in the cycle after a reset edge.
- **Latency:** let edge 1 be the first `clk` edge that samples a new raw level, with the raw level held stable. The debounced output changes at edge `DEBOUNCE_CYCLES+2`. The strobes assert at that same edge and deassert at the next.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles at the synchronizer output produces no output change and no strobe.
- Strobes are exactly one cycle wide. Back-to-back strobes are possible only if both channels are accepted on consecutive edges.
- If A and B are accepted on the same edge, the result is `err`. They are never treated as two sequential steps.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.

1. **Reset:** hold `reset_n=0` for 5 cycles with `a_raw=b_raw=1` → `a`, `b`, `change`, `cw`, `ccw`, `err` and `position` all remain 0 throughout.
2. **Clean clockwise step:** from 00, raise `a_raw` and hold → `a=1` at edge 6, with `change=cw=1` for exactly one cycle and `position` going 0→1. `b` stays 0.
3. **Bounce:** toggle `a_raw` every 2 cycles for 20 cycles, then hold 0 → `a` stays 0, no strobes, `position` stays 0.
4. **Counter-clockwise wrap:** walk 00→01→11→10→00, holding each state 10 cycles → exactly 4 `ccw` pulses, no `cw`/`err`, and `position` reads 255, 254, 253, 252.
5. **Simultaneous change:** from 00, raise `a_raw` and `b_raw` on the same cycle → `{a,b}` goes 00→11 at edge 6, with `err=change=1` for one cycle, no `cw`/`ccw`, and `position` unchanged.
6. **Reset mid-debounce:** raise `a_raw`, assert `reset_n=0` 3 cycles later for 1 cycle, then release with `a_raw` still 1 → `a=1` at edge 6 counted from the release, with a single `cw` pulse and `position=1`.
